// File: rtl/odd_parity_checker_fsm.sv
// Serial odd-parity frame receiver: DATA_W data bits LSB first, then one parity bit.
// Define ODD_PARITY_ERR_CNT_EN to build the saturating parity-error frame counter.
module odd_parity_checker_fsm #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              valid,
   input  logic              din,
   output logic [DATA_W-1:0] data_out,
   output logic              frame_done,
   output logic              parity_err,
   output logic              busy,
   output logic [7:0]        err_cnt
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [DATA_W-1:0]  shift_reg, shift_next;
   logic [DATA_W-1:0]  data_reg, data_next;
   logic               par_reg, par_next;
   logic               done_reg, done_next;
   logic               perr_reg, perr_next;
   logic               accept;

   // A data bit is taken only in DATA; load overrides any bit offered alongside it.
   assign accept = (state_reg == DATA) && valid && !load;

   // Each shift-register bit loads din only when the counter points at it.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_shift
         assign shift_next[gi] = load ? 1'b0 :
                                 (accept && (cnt_reg == CNT_W'(gi))) ? din :
                                 shift_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         shift_reg <= '0;
         data_reg  <= '0;
         par_reg   <= 1'b0;
         done_reg  <= 1'b0;
         perr_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         shift_reg <= shift_next;
         data_reg  <= data_next;
         par_reg   <= par_next;
         done_reg  <= done_next;
         perr_reg  <= perr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      par_next   = par_reg;
      data_next  = data_reg;
      perr_next  = perr_reg;
      done_next  = 1'b0;
      if (load) begin
         state_next = DATA;
         cnt_next   = '0;
         par_next   = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               state_next = IDLE;
            end
            DATA: begin
               if (valid) begin
                  par_next = par_reg ^ din;
                  if (cnt_reg == CNT_W'(DATA_W - 1)) begin
                     cnt_next   = '0;
                     state_next = PARITY;
                  end else begin
                     cnt_next = cnt_reg + CNT_W'(1);
                  end
               end
            end
            PARITY: begin
               if (valid) begin
                  data_next  = shift_reg;
                  // Even total ones count over data plus parity is an error.
                  perr_next  = ~(par_reg ^ din);
                  done_next  = 1'b1;
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign data_out   = data_reg;
   assign frame_done = done_reg;
   assign parity_err = perr_reg;
   assign busy       = (state_reg != IDLE);

`ifdef ODD_PARITY_ERR_CNT_EN
   logic [7:0] err_cnt_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt_reg <= 8'h00;
      end else if (done_next && perr_next && (err_cnt_reg != 8'hFF)) begin
         err_cnt_reg <= err_cnt_reg + 8'h01;
      end
   end

   assign err_cnt = err_cnt_reg;
`else
   assign err_cnt = 8'h00;
`endif

endmodule
